// File: rtl/ibex_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : ibex_hpm_counter_bank
// Description : Machine counter/timer bank. Holds mcycle (index 0), minstret
//               (index 2), MHPMCounterNum event counters (indices 3..), the
//               mcountinhibit register and the mhpmevent selectors. Decodes
//               the 0x320-0x33F, 0xB00-0xB1F and 0xB80-0xB9F CSR windows and
//               applies READ/WRITE/SET/CLEAR operations.
// Ports       : clk_i, rst_ni           - clock, async active-low reset
//               csr_access_i/addr/op/wdata - CSR access from the CSR file
//               csr_rdata_o             - combinational read data
//               csr_hit_o               - address lies in one of the windows
//               csr_illegal_o           - hit on an unimplemented index
//               instr_ret_i             - instruction retired strobe
//               event_i                 - event strobes for mhpmcounters
//               ovf_o                   - per-index wrap pulse (one cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_hpm_counter_bank #(
  parameter int unsigned MHPMCounterNum   = 8,
  parameter int unsigned MHPMCounterWidth = 40,
  parameter int unsigned NumEvents        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 csr_access_i,
  input  logic [11:0]          csr_addr_i,
  input  logic [1:0]           csr_op_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  output logic                 csr_illegal_o,
  input  logic                 instr_ret_i,
  input  logic [NumEvents-1:0] event_i,
  output logic [31:0]          ovf_o
);

  // csr_op_e encoding
  localparam logic [1:0] c_OP_READ  = 2'd0;
  localparam logic [1:0] c_OP_WRITE = 2'd1;
  localparam logic [1:0] c_OP_SET   = 2'd2;
  localparam logic [1:0] c_OP_CLEAR = 2'd3;

  // Bits kept by an mhpmcounter; everything above the width reads as 0.
  localparam logic [63:0] c_HPM_MASK = {64{1'b1}} >> (64 - MHPMCounterWidth);
  // One bit per implemented mhpmcounter, positioned at its index.
  localparam logic [63:0] c_HPM_BITS = ((64'd1 << MHPMCounterNum) - 64'd1) << 3;
  localparam logic [31:0] c_INH_MASK = c_HPM_BITS[31:0] | 32'h0000_0005;
  localparam logic [31:0] c_HPM_END  = 32'(3 + MHPMCounterNum);

  logic [4:0]  w_idx;
  logic        w_win_setup;
  logic        w_win_lo;
  logic        w_win_hi;
  logic        w_impl;
  logic        w_legal;
  logic [31:0] w_raw;
  logic [31:0] w_wval;
  logic        w_we;

  logic [31:0] r_inhibit;
  logic [63:0] w_cnt     [32];
  logic [31:0] w_evt_ext [32];
  logic [31:0] w_ovf;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  assign w_idx       = csr_addr_i[4:0];
  assign w_win_setup = csr_access_i && (csr_addr_i[11:5] == 7'h19);  // 0x320
  assign w_win_lo    = csr_access_i && (csr_addr_i[11:5] == 7'h58);  // 0xB00
  assign w_win_hi    = csr_access_i && (csr_addr_i[11:5] == 7'h5C);  // 0xB80

  assign w_impl = (w_idx == 5'd0) || (w_idx == 5'd2) ||
                  ((w_idx >= 5'd3) && ({27'd0, w_idx} < c_HPM_END));

  assign csr_hit_o     = w_win_setup || w_win_lo || w_win_hi;
  assign csr_illegal_o = csr_hit_o && !w_impl;
  assign w_legal       = csr_hit_o && w_impl;

  // --------------------------------------------------------------------------
  // Read mux (current state) and write-value computation
  // --------------------------------------------------------------------------
  always_comb begin
    w_raw = '0;
    if (w_win_setup) begin
      if (w_idx == 5'd0) begin
        w_raw = r_inhibit;
      end else begin
        w_raw = w_evt_ext[w_idx];
      end
    end else if (w_win_lo) begin
      w_raw = w_cnt[w_idx][31:0];
    end else if (w_win_hi) begin
      w_raw = w_cnt[w_idx][63:32];
    end
  end

  assign csr_rdata_o = w_legal ? w_raw : 32'd0;

  always_comb begin
    w_wval = csr_wdata_i;
    case (csr_op_i)
      c_OP_SET:   w_wval = w_raw | csr_wdata_i;
      c_OP_CLEAR: w_wval = w_raw & ~csr_wdata_i;
      default:    w_wval = csr_wdata_i;
    endcase
  end

  // SET/CLEAR with a zero operand are treated as pure reads.
  assign w_we = w_legal &&
                ((csr_op_i == c_OP_WRITE) ||
                 (((csr_op_i == c_OP_SET) || (csr_op_i == c_OP_CLEAR)) &&
                  (csr_wdata_i != 32'd0)));

  // --------------------------------------------------------------------------
  // mcountinhibit: a write lands at the clock edge, so the increments in the
  // write cycle still see the old value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inhibit <= '0;
    end else if (w_we && w_win_setup && (w_idx == 5'd0)) begin
      r_inhibit <= w_wval & c_INH_MASK;
    end
  end

  // --------------------------------------------------------------------------
  // Counter slots, one per index
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if ((i == 0) || (i == 2) || ((i >= 3) && (i < 3 + MHPMCounterNum))) begin : g_impl
      localparam logic [63:0] c_MASK = (i >= 3) ? c_HPM_MASK : {64{1'b1}};

      logic [63:0] r_cnt;
      logic        r_ovf;
      logic        w_tick;
      logic        w_wr_lo;
      logic        w_wr_hi;

      assign w_wr_lo = w_we && w_win_lo && (w_idx == 5'(i));
      assign w_wr_hi = w_we && w_win_hi && (w_idx == 5'(i));

      if (i == 0) begin : g_cycle
        assign w_tick       = ~r_inhibit[i];
        assign w_evt_ext[i] = 32'd0;
      end else if (i == 2) begin : g_instret
        assign w_tick       = ~r_inhibit[i] & instr_ret_i;
        assign w_evt_ext[i] = 32'd0;
      end else begin : g_hpm
        logic [NumEvents-1:0] r_evt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) begin
            r_evt <= '0;
          end else if (w_we && w_win_setup && (w_idx == 5'(i))) begin
            r_evt <= w_wval[NumEvents-1:0];
          end
        end

        assign w_tick       = ~r_inhibit[i] & (|(event_i & r_evt));
        assign w_evt_ext[i] = 32'(r_evt);
      end

      // A CSR write wins over the increment and never flags a wrap.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else begin
          r_ovf <= 1'b0;
          if (w_wr_lo) begin
            r_cnt <= {r_cnt[63:32], w_wval} & c_MASK;
          end else if (w_wr_hi) begin
            r_cnt <= {w_wval, r_cnt[31:0]} & c_MASK;
          end else if (w_tick) begin
            r_cnt <= (r_cnt + 64'd1) & c_MASK;
            r_ovf <= (r_cnt == c_MASK);
          end
        end
      end

      assign w_cnt[i] = r_cnt;
      assign w_ovf[i] = r_ovf;
    end else begin : g_unimpl
      assign w_cnt[i]     = 64'd0;
      assign w_ovf[i]     = 1'b0;
      assign w_evt_ext[i] = 32'd0;
    end
  end

  assign ovf_o = w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ibex_hpm_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_hpm_counter_bank
// Description : Directed self-checking bench for ibex_hpm_counter_bank.
//               Inputs change on the falling edge; outputs are sampled 1 ns
//               after it, well away from the rising (active) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_hpm_counter_bank;

  localparam int unsigned c_NUM = 8;
  localparam int unsigned c_WID = 40;
  localparam int unsigned c_EVT = 16;

  localparam logic [1:0] c_RD = 2'd0;
  localparam logic [1:0] c_WR = 2'd1;
  localparam logic [1:0] c_ST = 2'd2;
  localparam logic [1:0] c_CL = 2'd3;

  logic             clk_i;
  logic             rst_ni;
  logic             csr_access_i;
  logic [11:0]      csr_addr_i;
  logic [1:0]       csr_op_i;
  logic [31:0]      csr_wdata_i;
  logic [31:0]      csr_rdata_o;
  logic             csr_hit_o;
  logic             csr_illegal_o;
  logic             instr_ret_i;
  logic [c_EVT-1:0] event_i;
  logic [31:0]      ovf_o;

  int n_cmp  = 0;
  int n_fail = 0;

  ibex_hpm_counter_bank #(
    .MHPMCounterNum   (c_NUM),
    .MHPMCounterWidth (c_WID),
    .NumEvents        (c_EVT)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .csr_access_i  (csr_access_i),
    .csr_addr_i    (csr_addr_i),
    .csr_op_i      (csr_op_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_hit_o     (csr_hit_o),
    .csr_illegal_o (csr_illegal_o),
    .instr_ret_i   (instr_ret_i),
    .event_i       (event_i),
    .ovf_o         (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle and return all stimulus to idle.
  task automatic tick();
    @(negedge clk_i);
    csr_access_i = 1'b0;
    csr_addr_i   = 12'h000;
    csr_op_i     = c_RD;
    csr_wdata_i  = 32'd0;
    instr_ret_i  = 1'b0;
    event_i      = '0;
  endtask

  task automatic access(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_access_i = 1'b1;
    csr_addr_i   = a;
    csr_op_i     = op;
    csr_wdata_i  = d;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    access(a, op, d);
    tick();
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    access(a, c_RD, 32'd0);
    #1;
    check(tag, csr_rdata_o, exp);
    tick();
  endtask

  task automatic chk_ovf(input string tag, input logic [31:0] exp);
    #1;
    check(tag, ovf_o, exp);
  endtask

  initial begin
    rst_ni       = 1'b0;
    csr_access_i = 1'b0;
    csr_addr_i   = 12'h000;
    csr_op_i     = c_RD;
    csr_wdata_i  = 32'd0;
    instr_ret_i  = 1'b0;
    event_i      = '0;

    // ---------------- reset state ----------------
    #2;
    access(12'hB00, c_RD, 32'd0);
    #1;
    check("reset_rdata", csr_rdata_o, 32'd0);
    check("reset_ovf", ovf_o, 32'd0);
    csr_access_i = 1'b0;
    #1;
    check("noaccess_hit", {31'd0, csr_hit_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);

    // ---------------- idle 10 cycles ----------------
    rd("mcycle_lo_10", 12'hB00, 32'd10);
    rd("mcycle_hi_0", 12'hB80, 32'd0);
    rd("minstret_0", 12'hB02, 32'd0);
    chk_ovf("idle_ovf", 32'd0);

    // ---------------- minstret ----------------
    repeat (3) begin
      instr_ret_i = 1'b1;
      tick();
    end
    rd("minstret_3", 12'hB02, 32'd3);

    // ---------------- mcycle carry into the high half ----------------
    wr(12'hB00, c_WR, 32'hFFFF_FFFF);
    wr(12'hB80, c_WR, 32'd0);
    tick();
    rd("mcycle_carry_lo", 12'hB00, 32'd0);
    rd("mcycle_carry_hi", 12'hB80, 32'd1);
    chk_ovf("mcycle_carry_ovf", 32'd0);

    // ---------------- mcycle 64-bit wrap ----------------
    wr(12'hB00, c_WR, 32'hFFFF_FFFF);
    wr(12'hB80, c_WR, 32'hFFFF_FFFF);
    chk_ovf("mcycle_prewrap_ovf", 32'd0);
    tick();
    chk_ovf("mcycle_wrap_ovf", 32'h0000_0001);
    rd("mcycle_wrap_lo", 12'hB00, 32'd0);
    chk_ovf("mcycle_wrap_ovf_gone", 32'd0);

    // ---------------- mhpmcounter3 event selection ----------------
    wr(12'h323, c_WR, 32'h4);
    rd("mhpmevent3", 12'h323, 32'h4);
    repeat (5) begin
      event_i = 16'h0004;
      tick();
    end
    repeat (3) begin
      event_i = 16'h0001;
      tick();
    end
    rd("hpm3_count5", 12'hB03, 32'd5);
    wr(12'h320, c_ST, 32'h8);
    rd("inhibit_8", 12'h320, 32'h8);
    repeat (2) begin
      event_i = 16'h0004;
      tick();
    end
    rd("hpm3_inhibited", 12'hB03, 32'd5);

    // ---------------- 40-bit width and wrap ----------------
    wr(12'h320, c_WR, 32'd0);
    wr(12'hB83, c_WR, 32'hFFFF_FFFF);
    rd("hpm3_hi_masked", 12'hB83, 32'h0000_00FF);
    wr(12'hB03, c_WR, 32'hFFFF_FFFF);
    event_i = 16'h0004;
    chk_ovf("hpm3_prewrap_ovf", 32'd0);
    tick();
    chk_ovf("hpm3_wrap_ovf", 32'h0000_0008);
    rd("hpm3_wrap_lo", 12'hB03, 32'd0);
    chk_ovf("hpm3_ovf_gone", 32'd0);
    rd("hpm3_wrap_hi", 12'hB83, 32'd0);

    // Write overriding an event on an all-ones counter: no wrap, no pulse.
    wr(12'hB83, c_WR, 32'hFFFF_FFFF);
    wr(12'hB03, c_WR, 32'hFFFF_FFFF);
    access(12'hB03, c_WR, 32'd0);
    event_i = 16'h0004;
    tick();
    chk_ovf("hpm3_write_no_ovf", 32'd0);
    rd("hpm3_write_lo", 12'hB03, 32'd0);
    rd("hpm3_write_hi", 12'hB83, 32'h0000_00FF);

    // ---------------- write overrides increment ----------------
    wr(12'hB00, c_WR, 32'h0000_1234);
    rd("mcycle_written", 12'hB00, 32'h0000_1234);

    // ---------------- SET / CLEAR on mcountinhibit ----------------
    wr(12'h320, c_ST, 32'h5);
    wr(12'h320, c_CL, 32'h1);
    rd("inhibit_set_clear", 12'h320, 32'h4);
    wr(12'h320, c_ST, 32'hFFFF_FFFF);
    rd("inhibit_writable", 12'h320, 32'h0000_07FD);
    wr(12'h320, c_WR, 32'h4);

    // ---------------- mhpmevent width ----------------
    wr(12'h324, c_WR, 32'hFFFF_FFFF);
    rd("mhpmevent4_zext", 12'h324, 32'h0000_FFFF);

    // ---------------- illegal / out-of-window ----------------
    access(12'hB01, c_RD, 32'd0);
    #1;
    check("b01_illegal", {31'd0, csr_illegal_o}, 32'd1);
    check("b01_hit", {31'd0, csr_hit_o}, 32'd1);
    check("b01_rdata", csr_rdata_o, 32'd0);
    tick();
    access(12'hB0B, c_WR, 32'h77);
    #1;
    check("b0b_illegal", {31'd0, csr_illegal_o}, 32'd1);
    check("b0b_rdata", csr_rdata_o, 32'd0);
    tick();
    access(12'hB0A, c_RD, 32'd0);
    #1;
    check("b0a_legal", {31'd0, csr_illegal_o}, 32'd0);
    check("b0a_untouched", csr_rdata_o, 32'd0);
    tick();
    access(12'h300, c_WR, 32'h1);
    #1;
    check("x300_hit", {31'd0, csr_hit_o}, 32'd0);
    check("x300_illegal", {31'd0, csr_illegal_o}, 32'd0);
    check("x300_rdata", csr_rdata_o, 32'd0);
    tick();
    rd("inhibit_after_illegal", 12'h320, 32'h4);

    // ---------------- reset mid-operation drops pending pulse ----------------
    wr(12'hB80, c_WR, 32'hFFFF_FFFF);
    wr(12'hB00, c_WR, 32'hFFFF_FFFF);
    wr(12'h320, c_WR, 32'd0);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rst_ovf_dropped", ovf_o, 32'd0);
    access(12'hB80, c_RD, 32'd0);
    #1;
    check("rst_mcycle_cleared", csr_rdata_o, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibex_hpm_counter_bank.md
Name: ibex_hpm_counter_bank

Overview:
- Parametrised machine counter/timer unit: mcycle, minstret, a configurable number of mhpmcounters, mcountinhibit and mhpmevent selectors.
- Decodes the CSR_OFF_MCOUNTER_SETUP / CSR_OFF_MCOUNTER / CSR_OFF_MCOUNTERH / CSR_MASK_MCOUNTER address space and applies csr_op_e semantics.
- Sits beside ibex_cs_registers. The CSR file forwards accesses that fall in its space and muxes csr_rdata_o when csr_hit_o is set.

Parameters:
MHPMCounterNum, 8, number of mhpmcounters implemented, indices 3..3+N-1; legal range 0..29.
MHPMCounterWidth, 40, bits per mhpmcounter; legal range 1..64. mcycle and minstret are always 64 bits.
NumEvents, 16, width of event_i and of each mhpmevent selector; legal range 1..32.

Ports:
clk_i  input  1  core clock.
rst_ni  input  1  asynchronous active-low reset.
csr_access_i  input  1  CSR access valid this cycle.
csr_addr_i  input  12  CSR address.
csr_op_i  input  2  csr_op_e: READ, WRITE, SET, CLEAR.
csr_wdata_i  input  32  CSR operand.
csr_rdata_o  output  32  read data, combinational from the current state.
csr_hit_o  output  1  the address lies in the 0x320-0x33F, 0xB00-0xB1F or 0xB80-0xB9F window.
csr_illegal_o  output  1  access is a hit but targets an unimplemented index.
instr_ret_i  input  1  one instruction retired this cycle.
event_i  input  NumEvents  single-cycle event strobes.
ovf_o  output  32  one-cycle pulse per counter index when that counter wrapped on the previous cycle.

Behaviour:
- Reset: all counters, mcountinhibit and mhpmevent are 0; ovf_o = 0. csr_rdata_o, csr_hit_o and csr_illegal_o are combinational and are 0 when csr_access_i = 0.
- Index i = csr_addr_i[4:0].
- Implemented indices are 0, 2 and 3..3+MHPMCounterNum-1. Index 1 (time) and indices above the range are unimplemented. An access to an unimplemented index sets csr_illegal_o = 1, reads 0, and has no state effect.
- Address 0x320 is mcountinhibit.
  - Writable bits: 0, 2, and 3..3+N-1.
  - All other bits read 0.
- Address 0x323+k is mhpmevent for counter 3+k; it holds NumEvents bits, zero-extended on read.
- Address 0xB00+i is the low 32 bits of counter i; address 0xB80+i is the high 32 bits.
- Write value:
  - WRITE gives wdata.
  - SET gives rdata | wdata.
  - CLEAR gives rdata & ~wdata.
  - READ causes no write.
  - SET or CLEAR with wdata = 0 performs no write.
- Write latency: the new value is visible on csr_rdata_o the cycle after the access.
- Write to a low half replaces bits [31:0] and keeps the high half; a write to a high half does the reverse.
- Width rule for mhpmcounters:
  - Written bits at or above MHPMCounterWidth are discarded and read as 0.
  - If MHPMCounterWidth <= 32, the high half reads 0 and writes to it are ignored.
- Increments, each cycle, when the counter's mcountinhibit bit is 0:
  - mcycle: +1.
  - minstret: +instr_ret_i.
  - mhpmcounter j: +1 if |(event_i & mhpmevent[j]).
- A CSR write to either half of a counter overrides that counter's increment in the same cycle: the written value is stored, not written+1.
- An mcountinhibit write takes effect from the next cycle. The increment in the write cycle still uses the old inhibit value.
- Wrap-around:
  - A counter at all-ones (64 bits, or MHPMCounterWidth bits) that increments becomes 0.
  - ovf_o[i] pulses high for exactly the following cycle.
  - A CSR write never raises ovf_o.
- Reset asserted mid-operation clears all state immediately; any pending ovf_o pulse is dropped.
- Addresses outside the three windows: csr_hit_o = 0, csr_illegal_o = 0, csr_rdata_o = 0, and no state effect.

Test Plan:
- Reset, then idle 10 cycles → mcycle reads 10 at 0xB00 and 0 at 0xB80; minstret reads 0; ovf_o = 0.
- WRITE 0xFFFFFFFF to 0xB00, then WRITE 0 to 0xB80, then run 1 cycle → 0xB80 reads 1, 0xB00 reads 0; ovf_o[0] stays 0 because bit 63 did not wrap.
- mhpmevent3 = 0x4; pulse event_i[2] 5 times and event_i[0] 3 times → 0xB03 reads 5. Then set mcountinhibit bit 3 and pulse event_i[2] again → 0xB03 still reads 5.
- MHPMCounterWidth = 40: WRITE 0xFFFFFFFF to 0xB83 → reads 0xFF. Load the all-ones value and fire one event → counter reads 0, and ovf_o[3] is high for exactly 1 cycle.
- CSR write to 0xB00 in the same cycle mcycle would increment → reads back exactly the written value. SET 0x5 then CLEAR 0x1 on 0x320 → reads 0x4.
- Access 0xB01 and 0xB00+3+MHPMCounterNum → csr_illegal_o = 1, rdata = 0, no state change. Access 0x300 → csr_hit_o = 0.
